// File: rtl/cpu_bus_decoder.sv
// ============================================================================
// cpu_bus_decoder : aq32 CPU-side address decoder, slave mux, bus-error unit
// Revision 1.0    : initial release
// ============================================================================
`default_nettype none

module cpu_bus_decoder #(
    parameter int                         NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_BASE     = {32'h00000000, 32'hFFFF0000,
                                                            32'hFFF80000, 32'hFFF00000},
    parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK     = {32'hFFFF0000, 32'hFFFFF000,
                                                            32'hFFFF0000, 32'hFFF80000},
    parameter int                         TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               m_addr,
    input  logic                      m_wren,
    input  logic                      m_strobe,
    output logic                      m_wait,
    output logic [31:0]               m_rddata,
    output logic                      m_error,
    output logic [NUM_SLAVES-1:0]     s_strobe,
    input  logic [NUM_SLAVES-1:0]     s_wait,
    input  logic [32*NUM_SLAVES-1:0]  s_rddata,
    input  logic                      err_clear,
    output logic                      err_valid,
    output logic                      err_cause,
    output logic                      err_wren,
    output logic [31:0]               err_addr
);

    localparam int c_sel_w = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_err  = 2'd2;

    localparam bit                   c_timeout_en = (TIMEOUT_CYCLES != 0);
    localparam logic [c_cnt_w-1:0]   c_timeout    = c_cnt_w'(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0]   c_cnt_max    = '1;
    localparam logic [NUM_SLAVES-1:0] c_one       = NUM_SLAVES'(1);

    logic [1:0]          state_q, state_d;
    logic [c_sel_w-1:0]  sel_q, sel_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;

    logic [NUM_SLAVES-1:0] w_hit;
    logic [31:0]           w_rd [NUM_SLAVES];
    logic [c_sel_w-1:0]    w_dec_sel;
    logic                  w_any_hit;
    logic                  w_err_load;
    logic                  w_err_cause;

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_slave
        assign w_hit[i] = ((m_addr & SLAVE_MASK[32*i +: 32]) ==
                           (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32]));
        assign w_rd[i]  = s_rddata[32*i +: 32];
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_dec_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) w_dec_sel = c_sel_w'(i);
        end
    end

    assign w_any_hit = |w_hit;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        m_wait      = 1'b0;
        m_rddata    = '0;
        m_error     = 1'b0;
        s_strobe    = '0;
        w_err_load  = 1'b0;
        w_err_cause = 1'b0;

        case (state_q)
            c_st_idle: begin
                if (m_strobe) begin
                    if (w_any_hit) begin
                        s_strobe = c_one << w_dec_sel;
                        m_wait   = s_wait[w_dec_sel];
                        m_rddata = w_rd[w_dec_sel];
                        if (s_wait[w_dec_sel]) begin
                            sel_d   = w_dec_sel;
                            cnt_d   = c_cnt_w'(1);
                            state_d = c_st_busy;
                        end
                    end else begin
                        m_wait     = 1'b1;
                        w_err_load = 1'b1;
                        state_d    = c_st_err;
                    end
                end
            end
            c_st_busy: begin
                if (!m_strobe) begin
                    state_d = c_st_idle;
                end else begin
                    s_strobe = c_one << sel_q;
                    m_wait   = s_wait[sel_q];
                    m_rddata = w_rd[sel_q];
                    if (!s_wait[sel_q]) begin
                        state_d = c_st_idle;
                    end else if (c_timeout_en && (cnt_q == c_timeout)) begin
                        w_err_load  = 1'b1;
                        w_err_cause = 1'b1;
                        state_d     = c_st_err;
                    end else if (cnt_q != c_cnt_max) begin
                        cnt_d = cnt_q + c_cnt_w'(1);
                    end
                end
            end
            c_st_err: begin
                m_error = m_strobe;
                state_d = c_st_idle;
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= c_st_idle;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // A fresh error takes priority over a coincident clear request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_cause <= 1'b0;
            err_wren  <= 1'b0;
            err_addr  <= '0;
        end else if (w_err_load) begin
            err_valid <= 1'b1;
            err_cause <= w_err_cause;
            err_wren  <= m_wren;
            err_addr  <= m_addr;
        end else if (err_clear) begin
            err_valid <= 1'b0;
            err_cause <= 1'b0;
            err_wren  <= 1'b0;
            err_addr  <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_decoder.sv
// ============================================================================
// tb_cpu_bus_decoder : directed self-checking bench for cpu_bus_decoder
// Revision 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_decoder;

    logic         clk;
    logic         reset_n;
    logic [31:0]  m_addr;
    logic         m_wren;
    logic         m_strobe;
    logic [3:0]   s_wait;
    logic [127:0] s_rddata;
    logic         err_clear;

    // instance a: default windows, TIMEOUT 256
    logic m_wait_a, m_error_a, err_valid_a, err_cause_a, err_wren_a;
    logic [31:0] m_rddata_a, err_addr_a;
    logic [3:0]  s_strobe_a;
    // instance b: overlapping windows 0/1, TIMEOUT 4
    logic m_wait_b, m_error_b, err_valid_b, err_cause_b, err_wren_b;
    logic [31:0] m_rddata_b, err_addr_b;
    logic [3:0]  s_strobe_b;
    // instance c: default windows, timeout disabled
    logic m_wait_c, m_error_c, err_valid_c, err_cause_c, err_wren_c;
    logic [31:0] m_rddata_c, err_addr_c;
    logic [3:0]  s_strobe_c;

    int checks = 0;
    int errors = 0;

    cpu_bus_decoder dut_a (
        .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_wren(m_wren),
        .m_strobe(m_strobe), .m_wait(m_wait_a), .m_rddata(m_rddata_a),
        .m_error(m_error_a), .s_strobe(s_strobe_a), .s_wait(s_wait),
        .s_rddata(s_rddata), .err_clear(err_clear), .err_valid(err_valid_a),
        .err_cause(err_cause_a), .err_wren(err_wren_a), .err_addr(err_addr_a)
    );

    cpu_bus_decoder #(
        .NUM_SLAVES     (4),
        .SLAVE_BASE     ({32'h00000000, 32'hFFFF0000, 32'hFFF00000, 32'hFFF00000}),
        .SLAVE_MASK     ({32'hFFFF0000, 32'hFFFFF000, 32'hFFF80000, 32'hFFF80000}),
        .TIMEOUT_CYCLES (4)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_wren(m_wren),
        .m_strobe(m_strobe), .m_wait(m_wait_b), .m_rddata(m_rddata_b),
        .m_error(m_error_b), .s_strobe(s_strobe_b), .s_wait(s_wait),
        .s_rddata(s_rddata), .err_clear(err_clear), .err_valid(err_valid_b),
        .err_cause(err_cause_b), .err_wren(err_wren_b), .err_addr(err_addr_b)
    );

    cpu_bus_decoder #(
        .TIMEOUT_CYCLES (0)
    ) dut_c (
        .clk(clk), .reset_n(reset_n), .m_addr(m_addr), .m_wren(m_wren),
        .m_strobe(m_strobe), .m_wait(m_wait_c), .m_rddata(m_rddata_c),
        .m_error(m_error_c), .s_strobe(s_strobe_c), .s_wait(s_wait),
        .s_rddata(s_rddata), .err_clear(err_clear), .err_valid(err_valid_c),
        .err_cause(err_cause_c), .err_wren(err_wren_c), .err_addr(err_addr_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        m_strobe  = 1'b0;
        m_wren    = 1'b0;
        s_wait    = '0;
        err_clear = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
    endtask

    initial begin
        int bad;
        reset_n   = 1'b0;
        m_addr    = '0;
        m_wren    = 1'b0;
        m_strobe  = 1'b0;
        s_wait    = '0;
        err_clear = 1'b0;
        s_rddata  = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_m_wait",    32'(m_wait_a),    32'h0);
        chk("rst_m_error",   32'(m_error_a),   32'h0);
        chk("rst_m_rddata",  m_rddata_a,       32'h0);
        chk("rst_s_strobe",  32'(s_strobe_a),  32'h0);
        chk("rst_err_valid", 32'(err_valid_a), 32'h0);
        chk("rst_err_addr",  err_addr_a,       32'h0);

        // zero-wait read on slave 0
        @(negedge clk);
        m_addr = 32'hFFF00010; m_strobe = 1'b1; s_wait = 4'b0000;
        #1;
        chk("rd0_s_strobe", 32'(s_strobe_a), 32'h1);
        chk("rd0_m_wait",   32'(m_wait_a),   32'h0);
        chk("rd0_m_rddata", m_rddata_a,      32'hDEADBEEF);
        chk("rd0_m_error",  32'(m_error_a),  32'h0);

        // slave 1 waits three cycles
        @(negedge clk);
        m_addr = 32'hFFF81234; s_wait = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            chk("rd1_wait_m_wait",   32'(m_wait_a),   32'h1);
            chk("rd1_wait_s_strobe", 32'(s_strobe_a), 32'h2);
        end
        @(negedge clk);
        s_wait = 4'b0000;
        #1;
        chk("rd1_done_m_wait",   32'(m_wait_a), 32'h0);
        chk("rd1_done_m_rddata", m_rddata_a,    32'h11111111);
        chk("rd1_done_m_error",  32'(m_error_a), 32'h0);

        // back-to-back read on slave 3
        @(negedge clk);
        m_addr = 32'h00000100;
        #1;
        chk("b2b_s_strobe", 32'(s_strobe_a), 32'h8);
        chk("b2b_m_wait",   32'(m_wait_a),   32'h0);
        chk("b2b_m_rddata", m_rddata_a,      32'h33333333);

        // unmapped write
        @(negedge clk);
        m_addr = 32'h12340000; m_wren = 1'b1;
        #1;
        chk("unm_m_wait",   32'(m_wait_a),   32'h1);
        chk("unm_s_strobe", 32'(s_strobe_a), 32'h0);
        chk("unm_m_error0", 32'(m_error_a),  32'h0);
        @(negedge clk);
        #1;
        chk("unm_err_m_wait",   32'(m_wait_a),    32'h0);
        chk("unm_err_m_error",  32'(m_error_a),   32'h1);
        chk("unm_err_m_rddata", m_rddata_a,       32'h0);
        chk("unm_err_valid",    32'(err_valid_a), 32'h1);
        chk("unm_err_cause",    32'(err_cause_a), 32'h0);
        chk("unm_err_wren",     32'(err_wren_a),  32'h1);
        chk("unm_err_addr",     err_addr_a,       32'h12340000);
        @(negedge clk);
        m_strobe = 1'b0; m_wren = 1'b0;
        #1;
        chk("unm_after_m_error", 32'(m_error_a),   32'h0);
        chk("unm_sticky_valid",  32'(err_valid_a), 32'h1);

        // timeout on slave 2 with TIMEOUT_CYCLES = 4
        do_reset();
        @(negedge clk);
        m_addr = 32'hFFFF0000; m_strobe = 1'b1; s_wait = 4'b0100;
        #1;
        chk("to_idle_m_wait",   32'(m_wait_b),   32'h1);
        chk("to_idle_s_strobe", 32'(s_strobe_b), 32'h4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk("to_busy_s_strobe", 32'(s_strobe_b), 32'h4);
            chk("to_busy_m_wait",   32'(m_wait_b),   32'h1);
            chk("to_busy_m_error",  32'(m_error_b),  32'h0);
        end
        @(negedge clk);
        #1;
        chk("to_err_s_strobe", 32'(s_strobe_b),  32'h0);
        chk("to_err_m_wait",   32'(m_wait_b),    32'h0);
        chk("to_err_m_error",  32'(m_error_b),   32'h1);
        chk("to_err_valid",    32'(err_valid_b), 32'h1);
        chk("to_err_cause",    32'(err_cause_b), 32'h1);
        chk("to_err_addr",     err_addr_b,       32'hFFFF0000);

        // new unmapped error coincident with err_clear overwrites the timeout
        @(negedge clk);
        m_addr = 32'h12340000; m_wren = 1'b1; err_clear = 1'b1; s_wait = 4'b0000;
        #1;
        chk("coin_m_wait", 32'(m_wait_b), 32'h1);
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        chk("coin_m_error",  32'(m_error_b),   32'h1);
        chk("coin_valid",    32'(err_valid_b), 32'h1);
        chk("coin_cause",    32'(err_cause_b), 32'h0);
        chk("coin_wren",     32'(err_wren_b),  32'h1);
        chk("coin_addr",     err_addr_b,       32'h12340000);

        // plain clear
        @(negedge clk);
        m_strobe = 1'b0; m_wren = 1'b0; err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        #1;
        chk("clr_valid", 32'(err_valid_b), 32'h0);
        chk("clr_cause", 32'(err_cause_b), 32'h0);
        chk("clr_wren",  32'(err_wren_b),  32'h0);
        chk("clr_addr",  err_addr_b,       32'h0);

        // overlapping windows: lowest index wins
        @(negedge clk);
        m_addr = 32'hFFF00000; m_strobe = 1'b1;
        #1;
        chk("ovl_s_strobe", 32'(s_strobe_b), 32'h1);
        chk("ovl_m_rddata", m_rddata_b,      32'hDEADBEEF);

        // record an error, then reset in the middle of a busy access
        @(negedge clk);
        m_addr = 32'h00100000;
        @(negedge clk);
        #1;
        chk("pre_rst_m_error", 32'(m_error_b), 32'h1);
        chk("pre_rst_addr",    err_addr_b,     32'h00100000);
        @(negedge clk);
        m_addr = 32'hFFFF0000; s_wait = 4'b0100;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstb_busy_s_strobe", 32'(s_strobe_b),  32'h4);
        chk("rstb_busy_valid",    32'(err_valid_b), 32'h1);
        @(negedge clk);
        reset_n = 1'b1; m_strobe = 1'b0; s_wait = 4'b0000;
        #1;
        chk("rstb_s_strobe", 32'(s_strobe_b),  32'h0);
        chk("rstb_m_wait",   32'(m_wait_b),    32'h0);
        chk("rstb_m_error",  32'(m_error_b),   32'h0);
        chk("rstb_valid",    32'(err_valid_b), 32'h0);
        chk("rstb_addr",     err_addr_b,       32'h0);

        // timeout disabled: 1000 wait cycles never raise an error
        do_reset();
        @(negedge clk);
        m_addr = 32'hFFFF0000; m_strobe = 1'b1; s_wait = 4'b0100;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            #1;
            if (m_error_c !== 1'b0 || m_wait_c !== 1'b1 || s_strobe_c !== 4'b0100) bad++;
        end
        chk("nto_bad_cycles", 32'(bad), 32'h0);
        chk("nto_valid",      32'(err_valid_c), 32'h0);
        @(negedge clk);
        s_wait = 4'b0000;
        #1;
        chk("nto_done_m_wait",   32'(m_wait_c), 32'h0);
        chk("nto_done_m_rddata", m_rddata_c,    32'h22222222);
        chk("nto_done_m_error",  32'(m_error_c), 32'h0);
        @(negedge clk);
        m_strobe = 1'b0;
        #1;
        chk("nto_final_valid", 32'(err_valid_c), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_bus_decoder.md
Name: cpu_bus_decoder

Overview:
- Parametrised CPU-side bus interconnect for the aq32 core, replacing the single hard-wired SRAM window decode.
- Routes each CPU transaction to one of NUM_SLAVES address windows and muxes the slave's wait and read data back to the CPU.
- Generates bus errors for unmapped accesses and for slaves that exceed a wait-state timeout.
- Latches sticky error status for software or debug readout. Sits between the cpu instance and the SRAM, IO and video slaves.

Parameters:
NUM_SLAVES, 4, number of slave ports (1..8)
SLAVE_BASE, {32'h00000000, 32'hFFFF0000, 32'hFFF80000, 32'hFFF00000}, packed 32*NUM_SLAVES base addresses; slave i in bits [32i+31:32i]
SLAVE_MASK, {32'hFFFF0000, 32'hFFFFF000, 32'hFFFF0000, 32'hFFF80000}, packed 32*NUM_SLAVES decode masks
TIMEOUT_CYCLES, 256, maximum consecutive wait cycles before abort; 0 disables the timeout

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
m_addr  in  32  CPU byte address
m_wren  in  1  CPU write enable (recorded on error only)
m_strobe  in  1  CPU transaction request
m_wait  out  1  stall to CPU
m_rddata  out  32  read data to CPU
m_error  out  1  bus error; valid in the completion cycle
s_strobe  out  NUM_SLAVES  one-hot slave request
s_wait  in  NUM_SLAVES  per-slave wait
s_rddata  in  32*NUM_SLAVES  per-slave read data
err_clear  in  1  clears the sticky error status
err_valid  out  1  sticky: an error has occurred
err_cause  out  1  0 = unmapped, 1 = timeout
err_wren  out  1  m_wren of the faulting access
err_addr  out  32  m_addr of the faulting access

Behaviour:
- Decode rules:
  - hit[i] = ((m_addr & MASK[i]) == (BASE[i] & MASK[i])).
  - The lowest index wins on overlapping windows.
- Bus protocol:
  - The CPU holds m_addr and m_strobe stable while m_wait = 1.
  - A transaction completes in the cycle where m_strobe = 1 and m_wait = 0.
- State IDLE:
  - m_strobe & hit: s_strobe[sel] = 1 combinationally, m_wait = s_wait[sel], m_rddata = s_rddata[sel].
    - If s_wait[sel] = 0, the access completes in the same cycle (zero added latency) and the state stays IDLE.
    - Otherwise, latch sel, set cnt = 1 and go to BUSY.
  - m_strobe & no hit: m_wait = 1, no s_strobe, go to ERR.
- State BUSY:
  - s_strobe[sel_q] = 1, driven from the latched index.
  - m_wait and m_rddata are taken from slave sel_q.
  - s_wait low: complete and go to IDLE.
  - s_wait high: cnt += 1.
  - If TIMEOUT_CYCLES != 0 and cnt == TIMEOUT_CYCLES while s_wait is high: deassert s_strobe the next cycle, hold m_wait = 1, go to ERR with cause = 1.
- State ERR (exactly one cycle):
  - m_wait = 0, m_error = 1, m_rddata = 0, s_strobe = 0.
  - Go to IDLE. A new request is decoded from the next cycle.
- m_strobe dropping in BUSY or ERR (CPU abort): drop s_strobe the same cycle, go to IDLE, no error and no status update.
- Outputs outside these cases: m_wait = 0, m_rddata = 0, m_error = 0.
- Error status update:
  - On entry to ERR, set err_valid = 1 and load err_cause, err_wren and err_addr.
  - A later error overwrites the earlier one.
  - err_clear zeroes all four the next cycle.
  - err_clear in the same cycle as an ERR entry: the new error wins.
- Counter:
  - Width is $clog2(TIMEOUT_CYCLES+1) (minimum 1).
  - Saturates; never wraps.
- Reset:
  - State IDLE, sel_q = 0, cnt = 0, all err_* = 0.
  - Combinational outputs follow from IDLE: m_wait = 0, m_error = 0, m_rddata = 0, s_strobe = 0 when m_strobe = 0.
  - reset_n asserted mid-transaction aborts it: s_strobe drops the following cycle and no error is recorded.

Test Plan:
- Read 0xFFF00010, s_wait[0] = 0, s_rddata0 = 0xDEADBEEF -> s_strobe = 4'b0001, m_wait = 0, m_rddata = 0xDEADBEEF in the same cycle, m_error = 0.
- Read 0xFFF81234, s_wait[1] high for 3 cycles -> m_wait high for 3 cycles, then m_rddata = s_rddata1 with m_wait = 0; back-to-back read to 0x00000100 starts next cycle on s_strobe[3].
- Write 0x12340000 (unmapped) -> m_wait = 1 for 1 cycle, then m_error = 1 and m_wait = 0; err_valid = 1, err_cause = 0, err_wren = 1, err_addr = 0x12340000.
- TIMEOUT_CYCLES = 4, read 0xFFFF0000 with s_wait[2] stuck high -> s_strobe[2] drops after 4 wait cycles, m_error pulses 1 cycle, err_cause = 1; then err_clear -> err_valid = 0; err_clear coincident with a new unmapped error -> err_valid stays 1.
- Overlap override: BASE0 = BASE1 = 0xFFF00000, MASK = 0xFFF80000 -> access to 0xFFF00000 asserts only s_strobe[0].
- reset_n low during BUSY -> next cycle s_strobe = 0, m_wait = 0, err_valid = 0; TIMEOUT_CYCLES = 0 with s_wait held 1000 cycles -> no error.
